hsv_core_mem_tracker: RTL and testbench
=======================================

// Module: hsv_core_mem_tracker
// PURPOSE
//  Owns the memory-ordering counters that sequence hsv_core_mem_request: outstanding reads, outstanding
//  writes, commit-granted write balance, and fence readiness. Counts dmem.R/dmem.B completions, and after a
//  pipeline flush marks responses of transactions issued before the flush as stale until they drain.
//  Sits between hsv_core_mem_request, the mem response unit and commit.
// PARAMETERS
//  CounterWidth  8  width of mem_counter (signed); must equal $bits(mem_counter)
// PORTS
//  clk_core            in   1   core clock
//  rst_core_n          in   1   asynchronous active-low reset
//  flush               in   1   pipeline flush
//  pending_reads_up    in   1   request unit issued a read on dmem.AR this cycle
//  pending_writes_up   in   1   request unit issued a write on dmem.AW/W this cycle
//  write_balance_down  in   1   issued write was an ordinary memory write
//  write_balance_up    in   1   commit retired a memory store (grants one write)
//  dmem_r_done         in   1   dmem.R beat accepted (valid & ready)
//  dmem_b_done         in   1   dmem.B response accepted (valid & ready)
//  pending_reads       out  CW  mem_counter: reads issued, R not yet received
//  pending_writes      out  CW  mem_counter: writes issued, B not yet received
//  write_balance       out  CW  mem_counter (signed): granted minus issued memory writes
//  fence_ready         out  1   no transaction outstanding, tracker in RUN
//  counter_full        out  1   pending_reads or pending_writes at max positive value; request unit stalls
//  discard_r           out  1   current dmem.R beat belongs to a pre-flush read; drop it
//  discard_b           out  1   current dmem.B belongs to a pre-flush write; drop it
// BEHAVIOUR
//  - Reset: all counters 0, stale_reads/stale_writes 0, state RUN; fence_ready=1, counter_full=0,
//    discard_r=discard_b=0.
//  - All counters are registered; each updates one cycle after its event; outputs read from registers.
//  - pending_reads  <= pending_reads + up - r_done, where up = pending_reads_up & ~flush; same for writes
//    with pending_writes_up/dmem_b_done. Simultaneous up and done: net 0.
//  - *_up asserted in a flush cycle is ignored (request unit suppresses dmem valid under flush).
//  - write_balance <= write_balance + write_balance_up - (write_balance_down & ~flush); on flush it is
//    forced to 0 (uncommitted grants void), overriding both terms. Signed wrap is never legal: bench asserts.
//  - done with corresponding pending counter at 0 is a protocol error: counter holds at 0, bench asserts.
//  - counter_full = (pending_reads == max) | (pending_writes == max), max = 2^(CW-1)-1; no saturation logic
//    beyond that because issue is stalled combinationally by the request unit.
//  - FSM states RUN, DRAIN:
//    RUN: on flush, stale_reads <= pending_reads - r_done, stale_writes <= pending_writes - b_done;
//      if either result nonzero go DRAIN, else stay RUN.
//    DRAIN: discard_r = (stale_reads != 0), discard_b = (stale_writes != 0), combinational from registers.
//      r_done with stale_reads != 0 decrements stale_reads; same for b_done/stale_writes.
//      Return to RUN the cycle after both stale counters reach 0.
//      Flush in DRAIN re-snapshots as in RUN (every outstanding response becomes stale).
//    dmem responses are in-order per channel, so the first N completions after flush are the stale ones.
//  - fence_ready = (pending_reads == 0) & (pending_writes == 0) & (state == RUN); registered-value based,
//    so a fence following an issue sees fence_ready=0 from the next cycle onward.
//  - Reset mid-DRAIN: everything returns to reset values immediately; in-flight bus state is the
//    interconnect's responsibility.
// TESTING
//  1. Reset, pulse pending_reads_up x3, then r_done x3 -> pending_reads 1,2,3,2,1,0; fence_ready 1 only at 0.
//  2. Same-cycle pending_writes_up & dmem_b_done with pending_writes=2 -> stays 2; write_balance_down
//     with balance 1 -> balance 0, up+down together -> unchanged.
//  3. pending_reads=2, pending_writes=1, flush -> DRAIN, stale 2/1; next two R beats see discard_r=1,
//     third R (post-flush read) sees discard_r=0; RUN after the B arrives with discard_b=1.
//  4. flush with r_done and pending_reads=1 same cycle -> stale_reads 0, stays RUN, pending_reads 0.
//  5. write_balance=3, flush with write_balance_up -> balance 0; pending_reads_up during flush -> ignored.
//  6. Drive pending_reads to 127 (CW=8) -> counter_full=1; one r_done -> counter_full=0 next cycle.

Source files
------------

// File: rtl/hsv_core_mem_tracker.sv
// Memory-ordering counters for the core's dmem port: outstanding reads/writes, commit write
// balance, fence readiness, and post-flush stale-response discard tracking.
module hsv_core_mem_tracker #(
    parameter int unsigned CounterWidth = 8
) (
    input  logic                           clk_core,
    input  logic                           rst_core_n,
    input  logic                           flush,
    input  logic                           pending_reads_up,
    input  logic                           pending_writes_up,
    input  logic                           write_balance_down,
    input  logic                           write_balance_up,
    input  logic                           dmem_r_done,
    input  logic                           dmem_b_done,
    output logic        [CounterWidth-1:0] pending_reads,
    output logic        [CounterWidth-1:0] pending_writes,
    output logic signed [CounterWidth-1:0] write_balance,
    output logic                           fence_ready,
    output logic                           counter_full,
    output logic                           discard_r,
    output logic                           discard_b
);

    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } state_t;

    localparam logic [CounterWidth-1:0] CntMax = {1'b0, {(CounterWidth-1){1'b1}}};

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic        [CounterWidth-1:0]   r_pending_reads;
    logic        [CounterWidth-1:0]   r_pending_writes;
    logic signed [CounterWidth-1:0]   r_write_balance;
    logic        [CounterWidth-1:0]   r_stale_reads;
    logic        [CounterWidth-1:0]   r_stale_writes;
    logic        [CounterWidth-1:0]   w_stale_reads_nxt;
    logic        [CounterWidth-1:0]   w_stale_writes_nxt;
    logic                             w_rd_up;
    logic                             w_wr_up;
    logic                             w_rd_dn;
    logic                             w_wr_dn;
    logic                             w_wb_dn;

    // Issue is suppressed under flush; a completion with nothing outstanding is ignored.
    assign w_rd_up = pending_reads_up & ~flush;
    assign w_wr_up = pending_writes_up & ~flush;
    assign w_rd_dn = dmem_r_done & (r_pending_reads != '0);
    assign w_wr_dn = dmem_b_done & (r_pending_writes != '0);
    assign w_wb_dn = write_balance_down & ~flush;

    always_comb begin
        w_state_nxt        = r_state;
        w_stale_reads_nxt  = r_stale_reads;
        w_stale_writes_nxt = r_stale_writes;
        if (flush) begin
            w_stale_reads_nxt  = r_pending_reads - CounterWidth'(w_rd_dn);
            w_stale_writes_nxt = r_pending_writes - CounterWidth'(w_wr_dn);
            w_state_nxt = ((w_stale_reads_nxt != '0) || (w_stale_writes_nxt != '0)) ? ST_DRAIN : ST_RUN;
        end else if (r_state == ST_DRAIN) begin
            if (dmem_r_done && (r_stale_reads != '0)) begin
                w_stale_reads_nxt = r_stale_reads - 1'b1;
            end
            if (dmem_b_done && (r_stale_writes != '0)) begin
                w_stale_writes_nxt = r_stale_writes - 1'b1;
            end
            // Leave DRAIN only once both registered stale counts have already reached zero.
            if ((r_stale_reads == '0) && (r_stale_writes == '0)) begin
                w_state_nxt = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            r_state          <= ST_RUN;
            r_pending_reads  <= '0;
            r_pending_writes <= '0;
            r_write_balance  <= '0;
            r_stale_reads    <= '0;
            r_stale_writes   <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_stale_reads    <= w_stale_reads_nxt;
            r_stale_writes   <= w_stale_writes_nxt;
            r_pending_reads  <= r_pending_reads + CounterWidth'(w_rd_up) - CounterWidth'(w_rd_dn);
            r_pending_writes <= r_pending_writes + CounterWidth'(w_wr_up) - CounterWidth'(w_wr_dn);
            if (flush) begin
                r_write_balance <= '0;
            end else begin
                r_write_balance <= r_write_balance + CounterWidth'(write_balance_up)
                                   - CounterWidth'(w_wb_dn);
            end
        end
    end

    assign pending_reads  = r_pending_reads;
    assign pending_writes = r_pending_writes;
    assign write_balance  = r_write_balance;
    assign fence_ready    = (r_pending_reads == '0) && (r_pending_writes == '0) && (r_state == ST_RUN);
    assign counter_full   = (r_pending_reads == CntMax) || (r_pending_writes == CntMax);
    assign discard_r      = (r_state == ST_DRAIN) && (r_stale_reads != '0);
    assign discard_b      = (r_state == ST_DRAIN) && (r_stale_writes != '0);

endmodule

// File: tb/tb_hsv_core_mem_tracker.sv
// Bench for hsv_core_mem_tracker: directed scenarios plus random traffic checked against a
// transaction-queue reference model (each outstanding transaction tagged with its flush epoch).
module tb_hsv_core_mem_tracker;

    logic              clk_core = 1'b0;
    logic              rst_core_n = 1'b0;
    logic              flush = 1'b0;
    logic              pending_reads_up = 1'b0;
    logic              pending_writes_up = 1'b0;
    logic              write_balance_down = 1'b0;
    logic              write_balance_up = 1'b0;
    logic              dmem_r_done = 1'b0;
    logic              dmem_b_done = 1'b0;
    logic        [7:0] pending_reads;
    logic        [7:0] pending_writes;
    logic signed [7:0] write_balance;
    logic              fence_ready;
    logic              counter_full;
    logic              discard_r;
    logic              discard_b;

    int checks = 0;
    int failures = 0;

    // Reference model: in-order queues of outstanding transactions, each holding its issue epoch.
    int rq[$];
    int wq[$];
    int ep = 0;
    int wb = 0;
    bit drain = 1'b0;

    hsv_core_mem_tracker #(.CounterWidth(8)) dut (
        .clk_core          (clk_core),
        .rst_core_n        (rst_core_n),
        .flush             (flush),
        .pending_reads_up  (pending_reads_up),
        .pending_writes_up (pending_writes_up),
        .write_balance_down(write_balance_down),
        .write_balance_up  (write_balance_up),
        .dmem_r_done       (dmem_r_done),
        .dmem_b_done       (dmem_b_done),
        .pending_reads     (pending_reads),
        .pending_writes    (pending_writes),
        .write_balance     (write_balance),
        .fence_ready       (fence_ready),
        .counter_full      (counter_full),
        .discard_r         (discard_r),
        .discard_b         (discard_b)
    );

    always #5 clk_core = ~clk_core;

    function automatic int stale_r();
        int n = 0;
        foreach (rq[i]) if (rq[i] < ep) n++;
        return n;
    endfunction

    function automatic int stale_w();
        int n = 0;
        foreach (wq[i]) if (wq[i] < ep) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input int exp);
        logic [7:0] e;
        e = 8'(exp);
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
        end
    endtask

    task automatic check_all();
        int pr;
        int pw;
        pr = rq.size();
        pw = wq.size();
        check("pending_reads", pending_reads, pr);
        check("pending_writes", pending_writes, pw);
        check("write_balance", write_balance, wb);
        check("fence_ready", {7'd0, fence_ready}, (pr == 0 && pw == 0 && !drain) ? 1 : 0);
        check("counter_full", {7'd0, counter_full}, (pr == 127 || pw == 127) ? 1 : 0);
        check("discard_r", {7'd0, discard_r}, (drain && stale_r() > 0) ? 1 : 0);
        check("discard_b", {7'd0, discard_b}, (drain && stale_w() > 0) ? 1 : 0);
    endtask

    task automatic model_edge();
        int sr;
        int sw;
        sr = stale_r();
        sw = stale_w();
        if (dmem_r_done && rq.size() > 0) void'(rq.pop_front());
        if (dmem_b_done && wq.size() > 0) void'(wq.pop_front());
        if (flush) begin
            ep++;
            wb = 0;
            drain = (rq.size() != 0) || (wq.size() != 0);
        end else begin
            if (pending_reads_up) rq.push_back(ep);
            if (pending_writes_up) wq.push_back(ep);
            wb = wb + int'(write_balance_up) - int'(write_balance_down);
            if (drain && sr == 0 && sw == 0) drain = 1'b0;
        end
    endtask

    task automatic cyc(input bit fl, input bit ru, input bit wu, input bit wd,
                       input bit wbu, input bit rd, input bit bd);
        flush = fl;
        pending_reads_up = ru;
        pending_writes_up = wu;
        write_balance_down = wd;
        write_balance_up = wbu;
        dmem_r_done = rd;
        dmem_b_done = bd;
        @(posedge clk_core);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_core_n = 1'b0;
        {flush, pending_reads_up, pending_writes_up, write_balance_down} = '0;
        {write_balance_up, dmem_r_done, dmem_b_done} = '0;
        rq.delete();
        wq.delete();
        ep = 0;
        wb = 0;
        drain = 1'b0;
        #2;
        check_all();
        @(posedge clk_core);
        #1;
        rst_core_n = 1'b1;
    endtask

    initial begin
        bit fl, ru, wu, wd, wbu, rd, bd;
        #3;
        do_reset();

        // Reads up x3 then R x3.
        repeat (3) cyc(0, 1, 0, 0, 0, 0, 0);
        check("t1_pr3", pending_reads, 3);
        repeat (3) cyc(0, 0, 0, 0, 0, 1, 0);
        check("t1_fence", {7'd0, fence_ready}, 1);

        // Simultaneous up/done on writes; write balance arithmetic.
        repeat (2) cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 1);
        check("t2_pw_hold", pending_writes, 2);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("t2_wb0", write_balance, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        check("t2_wb_same", write_balance, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 1);

        // Flush with 2 reads / 1 write outstanding.
        do_reset();
        cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("t3_dr", {7'd0, discard_r}, 1);
        check("t3_db", {7'd0, discard_b}, 1);
        cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        check("t3_third_r_fresh", {7'd0, discard_r}, 0);
        cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("t3_run_fence", {7'd0, fence_ready}, 1);

        // Flush coincident with the only R.
        do_reset();
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 0);
        check("t4_fence", {7'd0, fence_ready}, 1);

        // Flush voids write balance and blocks issue.
        do_reset();
        repeat (3) cyc(0, 0, 0, 0, 1, 0, 0);
        check("t5_wb3", write_balance, 3);
        cyc(1, 1, 0, 0, 1, 0, 0);
        check("t5_wb0", write_balance, 0);
        check("t5_pr0", pending_reads, 0);

        // Counter full at 127.
        do_reset();
        repeat (127) cyc(0, 1, 0, 0, 0, 0, 0);
        check("t6_full", {7'd0, counter_full}, 1);
        cyc(0, 0, 0, 0, 0, 1, 0);
        check("t6_not_full", {7'd0, counter_full}, 0);

        // Reset in the middle of DRAIN.
        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 1, 0);
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Random legal traffic.
        for (int n = 0; n < 3000; n++) begin
            fl  = ($urandom_range(0, 24) == 0);
            ru  = (rq.size() < 127) ? 1'($urandom_range(0, 1)) : 1'b0;
            wu  = (wq.size() < 127) ? 1'($urandom_range(0, 1)) : 1'b0;
            rd  = (rq.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            bd  = (wq.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            wbu = (wb < 126) ? 1'($urandom_range(0, 1)) : 1'b0;
            wd  = (wb > -127) ? 1'($urandom_range(0, 1)) : 1'b0;
            cyc(fl, ru, wu, wd, wbu, rd, bd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
